// File: rtl/instcache_nway_if.sv
// Fetch-side and line-memory-side bus of the N-way instruction cache.
// The cache connects through the slave modport; the fetch stage and memory model use master.
interface instcache_nway_if #(
    parameter int line_w = 256
);
    logic              mem_read;
    logic [31:0]       mem_address;
    logic              mem_resp;
    logic [31:0]       mem_rdata;
    logic              flush;
    logic              pmem_read;
    logic [31:0]       pmem_address;
    logic [line_w-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_address, flush, pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata, pmem_read, pmem_address
    );

    modport master (
        output mem_read, mem_address, flush, pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata, pmem_read, pmem_address
    );
endinterface

// File: rtl/instcache_nway.sv
// N-way set-associative read-only instruction cache: tree PLRU, first-invalid victim, flush.
// Optional ICACHE_PERF_COUNT_EN adds 32-bit hit/miss counters (tied to 0 otherwise).
module instcache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic            clk,
    input  logic            rst,
    instcache_nway_if.slave bus,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);
    localparam int line_w = 8 * (2 ** s_offset);
    localparam int sets   = 2 ** s_index;
    localparam int way_w  = $clog2(num_ways);

    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;
    state_t state, state_nxt;

    logic [s_tag-1:0]    tag_q   [num_ways][sets];
    logic [line_w-1:0]   data_q  [num_ways][sets];
    logic [num_ways-1:0] valid_q [sets];
    logic [num_ways-2:0] plru_q  [sets];

    logic [way_w-1:0] victim, victim_q, hit_way;
    logic [31:0]      pmem_addr_q;
    logic             flush_pend, hit, resp;

    logic [s_index-1:0]  idx, f_idx;
    logic [s_tag-1:0]    tag, f_tag;
    logic [s_offset-3:0] wsel;
    logic [line_w-1:0]   hit_line;
    logic [num_ways-1:0] fill_mask;
    logic                unused_addr_bits;

    assign idx   = bus.mem_address[s_offset +: s_index];
    assign tag   = bus.mem_address[31 -: s_tag];
    assign wsel  = bus.mem_address[s_offset-1:2];
    assign f_idx = pmem_addr_q[s_offset +: s_index];
    assign f_tag = pmem_addr_q[31 -: s_tag];
    assign fill_mask = num_ways'(1) << victim_q;
    assign unused_addr_bits = ^bus.mem_address[1:0];

    // Walk the tree: a 0 bit sends the victim into the lower-indexed half.
    function automatic logic [way_w-1:0] plru_victim(input logic [num_ways-2:0] bits);
        int node;
        logic b;
        logic [way_w-1:0] v;
        node = 0;
        v = '0;
        for (int l = 0; l < way_w; l++) begin
            b = bits[node];
            v = (v << 1) | way_w'(b);
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                       input logic [way_w-1:0] w);
        int node;
        logic d;
        logic [num_ways-2:0] r;
        r = bits;
        node = 0;
        for (int l = way_w - 1; l >= 0; l--) begin
            d = w[l];
            r[node] = ~d;
            node = 2 * node + 1 + int'(d);
        end
        return r;
    endfunction

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < num_ways; w++)
            if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = way_w'(w);
            end
    end

    // Lowest-indexed invalid way wins over the PLRU choice.
    always_comb begin
        victim = plru_victim(plru_q[idx]);
        for (int w = num_ways - 1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = way_w'(w);
    end

    assign hit_line = data_q[hit_way][idx];

    always_comb begin
        state_nxt = state;
        resp = 1'b0;
        case (state)
            IDLE:
                if (!rst && !bus.flush && bus.mem_read) begin
                    if (hit) resp = 1'b1;
                    else     state_nxt = FETCH;
                end
            FETCH:   if (bus.pmem_resp) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_resp     = resp;
    assign bus.mem_rdata    = resp ? hit_line[{wsel, 5'd0} +: 32] : 32'd0;
    assign bus.pmem_read    = (state == FETCH);
    assign bus.pmem_address = pmem_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            victim_q    <= '0;
            pmem_addr_q <= '0;
            flush_pend  <= 1'b0;
            for (int s = 0; s < sets; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < sets; s++) valid_q[s] <= '0;
                    end else if (bus.mem_read && hit) begin
                        plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                    end else if (bus.mem_read) begin
                        victim_q    <= victim;
                        pmem_addr_q <= {tag, idx, {s_offset{1'b0}}};
                    end
                end
                FETCH: begin
                    if (bus.pmem_resp) begin
                        plru_q[f_idx] <= plru_touch(plru_q[f_idx], victim_q);
                        flush_pend    <= 1'b0;
                        // A flush seen during the fetch keeps only the line being filled.
                        if (flush_pend || bus.flush) begin
                            for (int s = 0; s < sets; s++) valid_q[s] <= '0;
                            valid_q[f_idx] <= fill_mask;
                        end else begin
                            valid_q[f_idx] <= valid_q[f_idx] | fill_mask;
                        end
                    end else if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        for (int s = 0; s < sets; s++) valid_q[s] <= '0;
                        valid_q[f_idx] <= fill_mask;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == FETCH && bus.pmem_resp) begin
            data_q[victim_q][f_idx] <= bus.pmem_rdata;
            tag_q[victim_q][f_idx]  <= f_tag;
        end
    end

`ifdef ICACHE_PERF_COUNT_EN
    logic from_fill;

    // The lookup right after FILL is the replay of a counted miss, not a new hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            from_fill  <= 1'b0;
        end else begin
            from_fill <= (state == FILL);
            if (resp && !from_fill) hit_count <= hit_count + 32'd1;
            if (state == IDLE && state_nxt == FETCH) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_instcache_nway.sv
// Bench for instcache_nway: directed scenarios plus random reads checked every cycle
// against a set/way/tree model of the cache; memory contents are a function of address.
module tb_instcache_nway;
    localparam int OFF = 5, SETS = 8, WAYS = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] hit_count, miss_count;

    instcache_nway_if #(.line_w(256)) bus();

    instcache_nway #(.s_offset(5), .s_index(3), .num_ways(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_of({a[31:5], 5'b0} + 32'(i * 4));
        return l;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_tag [WAYS][SETS];   // line address held by each way
    bit          m_val [WAYS][SETS];
    bit          m_ptr [SETS][WAYS-1]; // 1 = next victim in the upper half of that node's range
    int          ph;                   // 0 idle, 1 waiting on memory, 2 fill cycle
    int          m_victim;
    logic [31:0] m_faddr;
    bit          m_fpend, in_req, started;
    int unsigned m_hits, m_misses;

    function automatic int tree_victim(input int s);
        int node, lo, size;
        node = 0; lo = 0; size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (m_ptr[s][node]) begin lo += size; node = 2 * node + 2; end
            else node = 2 * node + 1;
        end
        return lo;
    endfunction

    task automatic tree_touch(input int s, input int w);
        int node, lo, size;
        node = 0; lo = 0; size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (w >= lo + size) begin m_ptr[s][node] = 1'b0; lo += size; node = 2 * node + 2; end
            else begin m_ptr[s][node] = 1'b1; node = 2 * node + 1; end
        end
    endtask

    task automatic clear_valid(input bit keep, input int kw, input int ks);
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_val[w][s] = 1'b0;
        if (keep) m_val[kw][ks] = 1'b1;
    endtask

    always @(negedge clk) begin
        int s, hw, fs;
        bit h, e_rsp;
        logic [31:0] la, e_rd, e_hc, e_mc;
        la = bus.mem_address >> OFF;
        s = int'(la % SETS);
        h = 1'b0; hw = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_val[w][s] && m_tag[w][s] == la) begin h = 1'b1; hw = w; end
        e_rsp = (ph == 0) && !rst && bus.mem_read && !bus.flush && h;
        e_rd  = e_rsp ? word_of(bus.mem_address) : 32'd0;
`ifdef ICACHE_PERF_COUNT_EN
        e_hc = m_hits; e_mc = m_misses;
`else
        e_hc = 0; e_mc = 0;
`endif
        if (started) begin
            check("mem_resp", 32'(bus.mem_resp), 32'(e_rsp));
            check("mem_rdata", bus.mem_rdata, e_rd);
            check("pmem_read", 32'(bus.pmem_read), 32'(ph == 1));
            check("pmem_address", bus.pmem_address, m_faddr);
            check("hit_count", hit_count, e_hc);
            check("miss_count", miss_count, e_mc);
        end
        fs = int'((m_faddr >> OFF) % SETS);
        if (rst) begin
            clear_valid(1'b0, 0, 0);
            for (int i = 0; i < SETS; i++)
                for (int j = 0; j < WAYS - 1; j++) m_ptr[i][j] = 1'b0;
            ph = 0; m_faddr = 0; m_fpend = 0; in_req = 0; m_hits = 0; m_misses = 0; m_victim = 0;
            started = 1'b1;
        end else begin
            case (ph)
                0: if (bus.flush) clear_valid(1'b0, 0, 0);
                   else if (bus.mem_read) begin
                       if (h) begin
                           tree_touch(s, hw);
                           if (!in_req) m_hits++;
                           in_req = 1'b0;
                       end else begin
                           m_victim = -1;
                           for (int w = WAYS - 1; w >= 0; w--) if (!m_val[w][s]) m_victim = w;
                           if (m_victim < 0) m_victim = tree_victim(s);
                           m_faddr = la << OFF;
                           m_misses++;
                           in_req = 1'b1;
                           ph = 1;
                       end
                   end
                1: if (bus.pmem_resp) begin
                       m_tag[m_victim][fs] = m_faddr >> OFF;
                       m_val[m_victim][fs] = 1'b1;
                       tree_touch(fs, m_victim);
                       if (m_fpend || bus.flush) clear_valid(1'b1, m_victim, fs);
                       m_fpend = 1'b0;
                       ph = 2;
                   end else if (bus.flush) m_fpend = 1'b1;
                default: begin
                    if (bus.flush) clear_valid(1'b1, m_victim, fs);
                    ph = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    int r_cyc, r_npr;
    logic [31:0] r_rd, r_pa;

    task automatic do_reset(input int n);
        bus.mem_read = 0; bus.flush = 0; bus.pmem_resp = 0;
        rst = 1;
        repeat (n) @(posedge clk);
        #1 rst = 0;
    endtask

    // Holds a request until mem_resp; memory answers after lat cycles of pmem_read.
    // flush_at >= 0 pulses flush in that waiting cycle; flush_fill pulses it in the FILL cycle.
    task automatic do_read(input logic [31:0] a, input int lat, input int flush_at, input bit flush_fill);
        int pend;
        bit done, was_resp;
        bus.mem_read = 1; bus.mem_address = a;
        pend = 0; done = 0; was_resp = 0;
        r_cyc = 0; r_npr = 0; r_rd = 0; r_pa = 0;
        while (!done) begin
            @(negedge clk);
            r_cyc++;
            if (bus.mem_resp) begin done = 1; r_rd = bus.mem_rdata; end
            if (bus.pmem_read) begin
                if (r_npr == 0) r_pa = bus.pmem_address;
                r_npr++;
            end
            @(posedge clk);
            #1;
            bus.flush = 0; bus.pmem_resp = 0;
            if (!done) begin
                if (was_resp && flush_fill) bus.flush = 1;
                else if (bus.pmem_read) begin
                    if (pend == flush_at) bus.flush = 1;
                    if (pend >= lat) begin
                        bus.pmem_resp = 1;
                        bus.pmem_rdata = line_of(bus.pmem_address);
                    end
                    pend++;
                end
            end
            was_resp = bus.pmem_resp;
            if (!done && r_cyc > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL read_timeout: got no mem_resp in %0d cycles for %h, expected a response", r_cyc, a);
                done = 1;
            end
        end
        bus.mem_read = 0;
    endtask

    task automatic idle_flush();
        bus.flush = 1;
        @(posedge clk);
        #1 bus.flush = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int k, r;
        bus.mem_read = 0; bus.mem_address = 0; bus.flush = 0;
        bus.pmem_resp = 0; bus.pmem_rdata = '0;
        do_reset(3);

        check("reset_mem_resp", 32'(bus.mem_resp), 0);
        check("reset_pmem_read", 32'(bus.pmem_read), 0);
        check("reset_pmem_address", bus.pmem_address, 0);
        check("reset_hit_count", hit_count, 0);

        // Cold miss then hit on the same line.
        do_read(32'h40, 3, -1, 0);
        check("miss_latency", r_cyc, 7);
        check("miss_pmem_address", r_pa, 32'h40);
        check("miss_rdata", r_rd, 32'hC0DE_0040);
        do_read(32'h4C, 0, -1, 0);
        check("hit_latency", r_cyc, 1);
        check("hit_no_pmem_read", r_npr, 0);
        check("hit_rdata", r_rd, 32'hC0DE_004C);

        // PLRU: fill set 0 with A..D, touch A, miss E evicts C.
        for (int i = 0; i < 4; i++) do_read(32'(i) << 8, 1, -1, 0);
        do_read(32'h000, 0, -1, 0);
        check("plru_hit_A", r_cyc, 1);
        do_read(32'h400, 2, -1, 0);
        check("plru_miss_E", 32'(r_npr > 0), 1);
        do_read(32'h004, 0, -1, 0); check("plru_keep_A", r_cyc, 1);
        do_read(32'h108, 0, -1, 0); check("plru_keep_B", r_cyc, 1);
        do_read(32'h31C, 0, -1, 0); check("plru_keep_D", r_cyc, 1);
        do_read(32'h200, 1, -1, 0); check("plru_evict_C", 32'(r_npr > 0), 1);

        // Idle flush drops both lines of set 1.
        do_read(32'h020, 1, -1, 0);
        do_read(32'h120, 1, -1, 0);
        idle_flush();
        do_read(32'h124, 1, -1, 0);
        check("flush_idle_miss", 32'(r_npr > 0), 1);

        // Flush during fetch keeps only the new line.
        do_read(32'h040, 0, -1, 0);
        do_read(32'h100, 3, 1, 0);
        do_read(32'h100, 0, -1, 0); check("flush_fetch_keep", r_cyc, 1);
        do_read(32'h040, 1, -1, 0); check("flush_fetch_drop", 32'(r_npr > 0), 1);

        // Reset in the middle of a fetch, then a stray memory response.
        bus.mem_read = 1; bus.mem_address = 32'h300;
        k = 0;
        while (!bus.pmem_read && k < 10) begin @(posedge clk); #1; k++; end
        @(posedge clk);
        #1 rst = 1; bus.mem_read = 0;
        @(posedge clk);
        #1 rst = 0; bus.pmem_resp = 1; bus.pmem_rdata = line_of(32'h300);
        @(negedge clk);
        check("rst_pmem_read", 32'(bus.pmem_read), 0);
        @(posedge clk);
        #1 bus.pmem_resp = 0;
        do_read(32'h040, 1, -1, 0); check("rst_drop_line", 32'(r_npr > 0), 1);

        // Counters: 3 misses and 5 hits from a clean reset.
        do_reset(2);
        do_read(32'h000, 1, -1, 0);
        do_read(32'h020, 1, -1, 0);
        do_read(32'h040, 1, -1, 0);
        do_read(32'h004, 0, -1, 0);
        do_read(32'h024, 0, -1, 0);
        do_read(32'h044, 0, -1, 0);
        do_read(32'h008, 0, -1, 0);
        do_read(32'h000, 0, -1, 0);
`ifdef ICACHE_PERF_COUNT_EN
        check("count_miss", miss_count, 3);
        check("count_hit", hit_count, 5);
`else
        check("count_miss", miss_count, 0);
        check("count_hit", hit_count, 0);
`endif

        // Random reads over two sets with conflict evictions and flushes.
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 1)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 19);
            if (r == 0) idle_flush();
            else do_read(a, $urandom_range(0, 4), (r < 3) ? $urandom_range(0, 4) : -1, r == 3);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instcache_nway.md
# instcache_nway

Parametrised N-way set-associative, read-only instruction cache combining tag/data storage, hit detection, tree pseudo-LRU replacement and the miss/fill state machine in one block. It sits between the fetch stage and the line-granular memory port, and returns one 32-bit word per request. It generalises the fixed 2-way, 8-set datapath to configurable way count, set count and line size, with flush support and first-invalid victim selection.

## Interface
- s_offset, 5, log2 of line size in bytes (line = 8*2**s_offset bits)
- s_index, 3, log2 of set count
- num_ways, 4, associativity; power of two, 2..8
- s_tag, 32-s_offset-s_index, derived tag width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  fetch request; held with mem_address until mem_resp
- mem_address  in  32  byte address; bits [1:0] ignored
- mem_resp  out  1  requested word valid this cycle
- mem_rdata  out  32  word at mem_address[s_offset-1:2] of hit line
- flush  in  1  single-cycle pulse: invalidate all lines
- pmem_read  out  1  line fetch request to memory
- pmem_address  out  32  line-aligned fetch address ({tag,index,0})
- pmem_rdata  in  2**s_offset*8  returned line, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle
- hit_count  out  32  hits since reset (see Configuration)
- miss_count  out  32  misses since reset (see Configuration)

## Operation
- Storage: per way, s_tag-bit tag, valid bit, line data, each 2**s_index entries, flop-based, combinational read. Per set, num_ways-1 PLRU bits.
- Lookup (IDLE): way w hits when valid[w][index] and tag[w][index]==mem_address tag. At most one way hits.
- PLRU: heap-ordered tree, node 0 root, children 2n+1/2n+2. Bit 0 → victim in lower-indexed half. On each hit response or fill to way w, every node on w's path is set to point away from w.
- Victim: lowest-indexed invalid way in set; if all valid, way selected by PLRU walk.
- FSM states: IDLE, FETCH, FILL.
  - IDLE: mem_read & hit → mem_resp=1, mem_rdata=selected word, PLRU update; stay. mem_read & miss → latch victim, go FETCH. No mem_resp on miss cycle.
  - FETCH: pmem_read=1, pmem_address={tag,index,s_offset'b0}. On pmem_resp: write pmem_rdata to victim way, write tag, set valid, PLRU update; go FILL.
  - FILL: one cycle; mem_resp=0; go IDLE, where request now hits.
- flush in IDLE: all valid bits cleared that cycle; mem_resp forced 0 that cycle; PLRU untouched.
- flush in FETCH or FILL: latched; applied on the pmem_resp write cycle (or FILL cycle if already past it) by clearing all valids except the just-filled way.

## Timing
- Reset: state IDLE, all valid 0, PLRU bits 0, flush latch 0, mem_resp 0, pmem_read 0, pmem_address 0, mem_rdata 0, counters 0. Tag/data not reset.
- rst overrides everything, including mid-FETCH; pmem_read deasserts next cycle, the pending pmem_resp is ignored.
- Hit latency: 0 cycles (mem_resp combinational in request cycle).
- Miss latency: request cycle N, pmem_read from N+1 until pmem_resp at cycle M, FILL at M+1, mem_resp at M+2.
- pmem_address and victim stable from N+1 through pmem_resp.
- pmem_resp in IDLE or FILL ignored.

## Configuration
- ICACHE_PERF_COUNT_EN defined: hit_count increments on each mem_resp cycle from IDLE lookup that did not come from a fill (first lookup of a request only); miss_count increments on each IDLE→FETCH transition; both 32-bit wrap-around, cleared by rst.
- Undefined: counter logic absent; hit_count and miss_count tied to 0.

## Test plan
- Reset then read 0x0000_0040: miss, pmem_address=0x40, pmem_resp after 3 cycles → mem_resp exactly 2 cycles after pmem_resp, correct word; repeat read → mem_resp same cycle, no pmem_read.
- num_ways=4, fill set 0 with tags A,B,C,D, hit A, then miss tag E → victim is way 2 (PLRU), C evicted, A,B,D still hit.
- Fill 2 ways of a set, flush, read either address → miss, pmem_read asserted.
- flush pulse during FETCH for 0x100 → after fill 0x100 hits, all previously cached lines miss.
- rst asserted mid-FETCH → pmem_read 0 next cycle, stray pmem_resp ignored, prior lines miss.
- With ICACHE_PERF_COUNT_EN: 3 misses, 5 hits → miss_count=3, hit_count=5; without: both read 0.
